// File: rtl/cnn_pkg.sv
// Shared CNN types: ALU opcodes, conv sequencer states and the command bundle.
package cnn_pkg;

  localparam int CNN_DATA_W = 32;
  localparam int CNN_ADDR_W = 32;
  localparam int CNN_TAP_W  = 8;

  typedef enum logic [3:0] {
    CNN_OP_IDLE = 4'b0000,
    CNN_OP_MUL  = 4'b0001,
    CNN_OP_VADD = 4'b0010
  } cnn_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACT,
    S_WT_ACT,
    S_RD_WGT,
    S_WT_WGT,
    S_ALU_ISS,
    S_ALU_WT,
    S_WRITE
  } cnn_seq_state_e;

  typedef struct packed {
    logic [CNN_ADDR_W-1:0] act_addr;
    logic [CNN_ADDR_W-1:0] wgt_addr;
    logic [CNN_ADDR_W-1:0] dst_addr;
    logic [CNN_TAP_W-1:0]  taps;
  } cnn_cmd_t;

endpackage

// File: rtl/cnn_tap_addr_gen.sv
// Activation/weight word pointers and tap counter for one conv dot-product.
module cnn_tap_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAP_W      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] act_addr,
  input  logic [ADDR_WIDTH-1:0] wgt_addr,
  input  logic [TAP_W-1:0]      taps,
  output logic [ADDR_WIDTH-1:0] act_ptr,
  output logic [ADDR_WIDTH-1:0] wgt_ptr,
  output logic [ADDR_WIDTH-1:0] act_next,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  logic [TAP_W-1:0] tap_cnt;
  logic [TAP_W-1:0] taps_q;

  // Pointers wrap modulo 2**ADDR_WIDTH without complaint.
  assign act_next = act_ptr + STEP;
  assign last     = (tap_cnt + TAP_W'(1)) == taps_q;

  // NOTE: rst_n is a synchronous, active-high reset despite its name.
  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      act_ptr <= '0;
      wgt_ptr <= '0;
      tap_cnt <= '0;
      taps_q  <= '0;
    end else if (load) begin
      act_ptr <= act_addr;
      wgt_ptr <= wgt_addr;
      tap_cnt <= '0;
      taps_q  <= taps;
    end else if (step) begin
      act_ptr <= act_next;
      wgt_ptr <= wgt_ptr + STEP;
      tap_cnt <= tap_cnt + TAP_W'(1);
    end
  end

endmodule

// File: rtl/cnn_conv_sequencer.sv
// Conv tap-loop sequencer: fetch act/wgt pairs, MUL on the CNN ALU, accumulate, write sum.
// Optional CNN_SEQ_RELU_EN clamps a negative sum to zero before the result write.
module cnn_conv_sequencer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_W,
  parameter int ADDR_WIDTH = CNN_ADDR_W,
  parameter int TAP_W      = CNN_TAP_W
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_act_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_wgt_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_dst_addr_i,
  input  logic [TAP_W-1:0]      cmd_taps_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [3:0]            alu_op_o,
  output logic                  alu_valid_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic                  alu_ready_i,
  input  logic                  alu_done_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i
);

  cnn_seq_state_e        state;
  cnn_cmd_t              cmd_in;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_sum;
  logic [ADDR_WIDTH-1:0] act_ptr;
  logic [ADDR_WIDTH-1:0] wgt_ptr;
  logic [ADDR_WIDTH-1:0] act_next;
  logic                  tap_last;
  logic                  accept;
  logic                  tap_step;

  function automatic logic [DATA_WIDTH-1:0] result_word(input logic [DATA_WIDTH-1:0] v);
`ifdef CNN_SEQ_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign cmd_in   = '{act_addr: cmd_act_addr_i, wgt_addr: cmd_wgt_addr_i,
                      dst_addr: cmd_dst_addr_i, taps: cmd_taps_i};
  assign accept   = (state == S_IDLE) && cmd_valid_i;
  assign tap_step = (state == S_ALU_WT) && alu_done_i;
  assign acc_sum  = acc + alu_result_i;

  cnn_tap_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .TAP_W      (TAP_W)
  ) u_addr_gen (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (tap_step),
    .act_addr (cmd_in.act_addr),
    .wgt_addr (cmd_in.wgt_addr),
    .taps     (cmd_in.taps),
    .act_ptr  (act_ptr),
    .wgt_ptr  (wgt_ptr),
    .act_next (act_next),
    .last     (tap_last)
  );

  // NOTE: every register here uses <= so each branch reads pre-edge values of its peers.
  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      state       <= S_IDLE;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      alu_op_o    <= CNN_OP_IDLE;
      alu_valid_o <= 1'b0;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
      acc         <= '0;
      dst_q       <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            acc         <= '0;
            dst_q       <= cmd_in.dst_addr;
            mem_req_o   <= 1'b1;
            if (cmd_in.taps == '0) begin
              state       <= S_WRITE;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= cmd_in.dst_addr;
              mem_wdata_o <= '0;
            end else begin
              state      <= S_RD_ACT;
              mem_we_o   <= 1'b0;
              mem_addr_o <= cmd_in.act_addr;
            end
          end
        end
        S_RD_ACT: if (mem_gnt_i) begin
          mem_req_o <= 1'b0;
          state     <= S_WT_ACT;
        end
        S_WT_ACT: if (mem_rvalid_i) begin
          alu_a_o    <= mem_rdata_i;
          mem_req_o  <= 1'b1;
          mem_addr_o <= wgt_ptr;
          state      <= S_RD_WGT;
        end
        S_RD_WGT: if (mem_gnt_i) begin
          mem_req_o <= 1'b0;
          state     <= S_WT_WGT;
        end
        S_WT_WGT: if (mem_rvalid_i) begin
          alu_b_o     <= mem_rdata_i;
          alu_valid_o <= 1'b1;
          alu_op_o    <= CNN_OP_MUL;
          state       <= S_ALU_ISS;
        end
        S_ALU_ISS: if (alu_ready_i) begin
          alu_valid_o <= 1'b0;
          alu_op_o    <= CNN_OP_IDLE;
          state       <= S_ALU_WT;
        end
        S_ALU_WT: if (alu_done_i) begin
          acc       <= acc_sum;
          mem_req_o <= 1'b1;
          if (tap_last) begin
            // Write the freshly updated sum directly; acc itself lags by a cycle.
            mem_we_o    <= 1'b1;
            mem_addr_o  <= dst_q;
            mem_wdata_o <= result_word(acc_sum);
            state       <= S_WRITE;
          end else begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= act_next;
            state      <= S_RD_ACT;
          end
        end
        S_WRITE: if (mem_gnt_i) begin
          mem_req_o   <= 1'b0;
          mem_we_o    <= 1'b0;
          done_o      <= 1'b1;
          busy_o      <= 1'b0;
          cmd_ready_o <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // act_ptr is consumed through act_next; keep it observable for the first fetch address only.
  logic unused_ok;
  assign unused_ok = ^act_ptr;

endmodule

// File: tb/tb_cnn_conv_sequencer.sv
// Directed bench for cnn_conv_sequencer with a memory model and a MUL ALU model.
module tb_cnn_conv_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_act_addr_i = '0;
  logic [31:0] cmd_wgt_addr_i = '0;
  logic [31:0] cmd_dst_addr_i = '0;
  logic [7:0]  cmd_taps_i = '0;
  logic        busy_o, done_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [3:0]  alu_op_o;
  logic        alu_valid_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic        alu_ready_i;
  logic        alu_done_i = 1'b0;
  logic [31:0] alu_result_i = '0;

  int checks = 0;
  int errors = 0;

  cnn_conv_sequencer dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_act_addr_i (cmd_act_addr_i),
    .cmd_wgt_addr_i (cmd_wgt_addr_i),
    .cmd_dst_addr_i (cmd_dst_addr_i),
    .cmd_taps_i     (cmd_taps_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .alu_op_o       (alu_op_o),
    .alu_valid_o    (alu_valid_o),
    .alu_a_o        (alu_a_o),
    .alu_b_o        (alu_b_o),
    .alu_ready_i    (alu_ready_i),
    .alu_done_i     (alu_done_i),
    .alu_result_i   (alu_result_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: grant after gnt_delay waiting cycles, read data rv_delay cycles after grant.
  logic [31:0] mem [int unsigned];
  int          gnt_delay = 0;
  int          rv_delay  = 1;
  int          req_cnt   = 0;
  int          rv_cnt    = 0;
  logic [31:0] rv_data   = '0;
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];

  assign mem_gnt_i = mem_req_o && (req_cnt >= gnt_delay);

  always @(posedge clk_i) begin
    mem_rvalid_i <= 1'b0;
    if (mem_req_o && !mem_gnt_i) req_cnt <= req_cnt + 1;
    else                         req_cnt <= 0;
    if (rv_cnt > 0) begin
      if (rv_cnt == 1) begin
        mem_rvalid_i <= 1'b1;
        mem_rdata_i  <= rv_data;
      end
      rv_cnt <= rv_cnt - 1;
    end
    if (mem_gnt_i) begin
      if (mem_we_o) begin
        wr_addr_log.push_back(mem_addr_o);
        wr_data_log.push_back(mem_wdata_o);
      end else begin
        rd_log.push_back(mem_addr_o);
        if (rv_delay <= 1) begin
          mem_rvalid_i <= 1'b1;
          mem_rdata_i  <= mem.exists(mem_addr_o) ? mem[mem_addr_o] : 32'h0;
        end else begin
          rv_data <= mem.exists(mem_addr_o) ? mem[mem_addr_o] : 32'h0;
          rv_cnt  <= rv_delay - 1;
        end
      end
    end
  end

  // ALU model: ready after rdy_delay waiting cycles, product one cycle after ready.
  int rdy_delay = 0;
  int alu_cnt   = 0;
  int alu_ops   = 0;

  assign alu_ready_i = alu_valid_o && (alu_cnt >= rdy_delay);

  always @(posedge clk_i) begin
    alu_done_i <= 1'b0;
    if (alu_valid_o && !alu_ready_i) alu_cnt <= alu_cnt + 1;
    else                             alu_cnt <= 0;
    if (alu_ready_i) begin
      alu_done_i   <= 1'b1;
      alu_result_i <= 32'(alu_a_o * alu_b_o);
      alu_ops      <= alu_ops + 1;
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    alu_ops = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b0;
  endtask

  // Checks every output against its reset value at the current negedge.
  task automatic check_idle_outputs(input string tag);
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_cmd_ready got %b expected 1", tag, cmd_ready_o);
    end
    checks++;
    if ({busy_o, done_o, mem_req_o, mem_we_o, alu_valid_o} !== 5'b0) begin
      errors++;
      $display("FAIL %s_ctrl {busy,done,req,we,alu_valid} got %b expected 00000", tag,
               {busy_o, done_o, mem_req_o, mem_we_o, alu_valid_o});
    end
    checks++;
    if (alu_op_o !== 4'b0000) begin
      errors++;
      $display("FAIL %s_alu_op got %h expected 0", tag, alu_op_o);
    end
    checks++;
    if ({mem_addr_o, mem_wdata_o} !== 64'h0) begin
      errors++;
      $display("FAIL %s_mem_addr_wdata got %h/%h expected 0/0", tag, mem_addr_o, mem_wdata_o);
    end
    checks++;
    if ({alu_a_o, alu_b_o} !== 64'h0) begin
      errors++;
      $display("FAIL %s_alu_ab got %h/%h expected 0/0", tag, alu_a_o, alu_b_o);
    end
  endtask

  // Issues one command and follows it to done. lat counts negedges after the accept edge
  // (1 = first cycle after accept); -1 if done never came. hold_errs counts requests that
  // changed or dropped while waiting on gnt / alu_ready.
  task automatic run_cmd(input logic [31:0] act, input logic [31:0] wgt, input logic [31:0] dst,
                         input logic [7:0] taps, output int lat, output int dones,
                         output logic busy1, output int hold_errs);
    logic        p_req, p_gnt, p_we, p_av, p_ar;
    logic [31:0] p_addr, p_a, p_b;
    logic [3:0]  p_op;
    int          w;
    @(negedge clk_i);
    cmd_act_addr_i = act;
    cmd_wgt_addr_i = wgt;
    cmd_dst_addr_i = dst;
    cmd_taps_i     = taps;
    cmd_valid_i    = 1'b1;
    w = 0;
    while (cmd_ready_o !== 1'b1 && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    lat = -1; dones = 0; hold_errs = 0; busy1 = busy_o;
    p_req = 1'b0; p_gnt = 1'b0; p_we = 1'b0; p_addr = '0;
    p_av = 1'b0; p_ar = 1'b0; p_a = '0; p_b = '0; p_op = '0;
    for (int n = 1; n <= 2000; n++) begin
      if (p_req && !p_gnt && (!mem_req_o || mem_addr_o !== p_addr || mem_we_o !== p_we))
        hold_errs++;
      if (p_av && !p_ar && (!alu_valid_o || alu_a_o !== p_a || alu_b_o !== p_b || alu_op_o !== p_op))
        hold_errs++;
      p_req = mem_req_o; p_gnt = mem_gnt_i; p_we = mem_we_o; p_addr = mem_addr_o;
      p_av = alu_valid_o; p_ar = alu_ready_i; p_a = alu_a_o; p_b = alu_b_o; p_op = alu_op_o;
      if (done_o === 1'b1) begin
        dones++;
        if (lat < 0) lat = n;
      end
      if (lat >= 0 && n >= lat + 3) break;
      @(negedge clk_i);
    end
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] addr,
                             input logic [31:0] data);
    checks++;
    if (wr_addr_log.size() <= idx) begin
      errors++;
      $display("FAIL %s_write missing: %0d writes seen, need index %0d", tag, wr_addr_log.size(), idx);
    end else if (wr_addr_log[idx] !== addr || wr_data_log[idx] !== data) begin
      errors++;
      $display("FAIL %s_write got %h=%h expected %h=%h", tag, wr_addr_log[idx], wr_data_log[idx],
               addr, data);
    end
  endtask

  task automatic load_dot3();
    mem[32'h100] = 32'd2; mem[32'h104] = 32'd3; mem[32'h108] = 32'd4;
    mem[32'h200] = 32'd5; mem[32'h204] = 32'd6; mem[32'h208] = 32'd7;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    check_idle_outputs("reset");
  endtask

  task automatic test_dot3();
    int lat, dones, holds;
    logic b1;
    logic [31:0] exp_rd [6];
    exp_rd = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};
    clear_logs();
    load_dot3();
    run_cmd(32'h100, 32'h200, 32'h300, 8'd3, lat, dones, b1, holds);
    checks++;
    if (rd_log.size() !== 6) begin
      errors++;
      $display("FAIL dot3_read_count got %0d expected 6", rd_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rd_log[i] !== exp_rd[i]) begin
          errors++;
          $display("FAIL dot3_read_%0d got %h expected %h", i, rd_log[i], exp_rd[i]);
        end
      end
    end
    checks++;
    if (wr_addr_log.size() !== 1) begin
      errors++;
      $display("FAIL dot3_write_count got %0d expected 1", wr_addr_log.size());
    end
    check_write("dot3", 0, 32'h300, 32'd56);
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL dot3_done_pulses got %0d expected 1", dones);
    end
    // Six cycles per tap, plus the WRITE cycle, done one cycle after the grant.
    checks++;
    if (lat !== 20) begin
      errors++;
      $display("FAIL dot3_latency got %0d expected 20", lat);
    end
    checks++;
    if (b1 !== 1'b1 || alu_ops !== 3) begin
      errors++;
      $display("FAIL dot3_busy_aluops got busy=%b ops=%0d expected busy=1 ops=3", b1, alu_ops);
    end
  endtask

  task automatic test_zero_taps();
    int lat, dones, holds;
    logic b1;
    clear_logs();
    run_cmd(32'h100, 32'h200, 32'h340, 8'd0, lat, dones, b1, holds);
    checks++;
    if (rd_log.size() !== 0 || alu_ops !== 0) begin
      errors++;
      $display("FAIL zero_no_reads got reads=%0d ops=%0d expected 0/0", rd_log.size(), alu_ops);
    end
    check_write("zero", 0, 32'h340, 32'h0);
    // Accept cycle, WRITE cycle, then done: third cycle of the command.
    checks++;
    if (lat !== 2 || dones !== 1) begin
      errors++;
      $display("FAIL zero_latency got lat=%0d pulses=%0d expected 2/1", lat, dones);
    end
  endtask

  task automatic test_stall();
    int lat, dones, holds;
    logic b1;
    clear_logs();
    gnt_delay = 4;
    rdy_delay = 3;
    run_cmd(32'h100, 32'h200, 32'h380, 8'd3, lat, dones, b1, holds);
    gnt_delay = 0;
    rdy_delay = 0;
    check_write("stall", 0, 32'h380, 32'd56);
    checks++;
    if (holds !== 0) begin
      errors++;
      $display("FAIL stall_hold got %0d unstable cycles expected 0", holds);
    end
    // Per tap: 5+1+5+1+4+1 = 17 cycles; WRITE takes 5; +1 to done.
    checks++;
    if (lat !== 57) begin
      errors++;
      $display("FAIL stall_latency got %0d expected 57", lat);
    end
  endtask

  task automatic test_negative();
    int lat, dones, holds;
    logic b1;
    logic [31:0] exp;
`ifdef CNN_SEQ_RELU_EN
    exp = 32'h0;
`else
    exp = 32'hFFFF_FFF6;
`endif
    clear_logs();
    mem[32'h400] = 32'hFFFF_FFFE;
    mem[32'h500] = 32'd5;
    run_cmd(32'h400, 32'h500, 32'h600, 8'd1, lat, dones, b1, holds);
    check_write("negative", 0, 32'h600, exp);
  endtask

  task automatic test_reset_mid();
    int lat, dones, holds;
    logic b1;
    clear_logs();
    rv_delay = 4;
    @(negedge clk_i);
    cmd_act_addr_i = 32'h100;
    cmd_wgt_addr_i = 32'h200;
    cmd_dst_addr_i = 32'h800;
    cmd_taps_i     = 8'd2;
    cmd_valid_i    = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    // WT_ACT spans cycles 2-5, RD_WGT cycle 6, WT_WGT from cycle 7 with rvalid due in cycle 10.
    repeat (7) @(negedge clk_i);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_n = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("midreset");
    checks++;
    if (wr_addr_log.size() !== 0 || alu_ops !== 0) begin
      errors++;
      $display("FAIL midreset_aborted got writes=%0d ops=%0d expected 0/0", wr_addr_log.size(),
               alu_ops);
    end
    rv_delay = 1;
    clear_logs();
    run_cmd(32'h100, 32'h200, 32'h900, 8'd3, lat, dones, b1, holds);
    check_write("after_reset", 0, 32'h900, 32'd56);
    checks++;
    if (lat !== 20) begin
      errors++;
      $display("FAIL after_reset_latency got %0d expected 20", lat);
    end
  endtask

  task automatic test_back_to_back();
    int n, early, w;
    clear_logs();
    @(negedge clk_i);
    cmd_act_addr_i = 32'h100; cmd_wgt_addr_i = 32'h200; cmd_dst_addr_i = 32'h700; cmd_taps_i = 8'd1;
    cmd_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_act_addr_i = 32'h104; cmd_wgt_addr_i = 32'h204; cmd_dst_addr_i = 32'h704; cmd_taps_i = 8'd2;
    early = 0;
    n = 0;
    while (done_o !== 1'b1 && n < 200) begin
      if (cmd_ready_o !== 1'b0) early++;
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (done_o !== 1'b1 || cmd_ready_o !== 1'b1 || early !== 0) begin
      errors++;
      $display("FAIL b2b_handover got done=%b ready=%b early_ready=%0d expected 1/1/0", done_o,
               cmd_ready_o, early);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    checks++;
    if ({busy_o, done_o, cmd_ready_o} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_second_accept {busy,done,ready} got %b expected 100",
               {busy_o, done_o, cmd_ready_o});
    end
    w = 0;
    while (done_o !== 1'b1 && w < 200) begin
      @(negedge clk_i);
      w++;
    end
    checks++;
    if (wr_addr_log.size() !== 2) begin
      errors++;
      $display("FAIL b2b_write_count got %0d expected 2", wr_addr_log.size());
    end
    check_write("b2b_first", 0, 32'h700, 32'd10);
    check_write("b2b_second", 1, 32'h704, 32'd46);
  endtask

  initial begin
    test_reset();
    test_dot3();
    test_zero_taps();
    test_stall();
    test_negative();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
